// File: rtl/mlp_infer_seq_pkg.sv
// Shared configuration for the MLP inference sequencer: default sizes, state
// encoding and a width helper used by the top and the argmax unit.
package mlp_infer_seq_pkg;

  localparam int DEF_NUM_INPUTS  = 784;
  localparam int DEF_NUM_HIDDEN  = 128;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_PIX_W       = 8;
  localparam int DEF_SCORE_W     = 48;
  localparam int DEF_L1_LAT      = 2;
  localparam int DEF_L2_LAT      = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLR      = 3'd1,
    S_L1_RUN   = 3'd2,
    S_L1_DRAIN = 3'd3,
    S_L2_RUN   = 3'd4,
    S_L2_DRAIN = 3'd5,
    S_ARGMAX   = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // Index width for n items; never below one bit so degenerate sizes still elaborate.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_argmax.sv
// Sequential signed argmax: one class per cycle. idx/max_val show the result
// including the score selected this cycle, so the caller can latch it on the last step.
module seq_argmax
  import mlp_infer_seq_pkg::*;
#(
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             step,
  input  logic [width_of(NUM_CLASSES)-1:0] index,
  input  logic [NUM_CLASSES*SCORE_W-1:0]   scores,
  output logic [width_of(NUM_CLASSES)-1:0] idx,
  output logic [SCORE_W-1:0]               max_val
);

  logic [width_of(NUM_CLASSES)-1:0] best_idx;
  logic [SCORE_W-1:0]               best_max;
  logic [SCORE_W-1:0]               cur;

  assign cur = scores[index*SCORE_W +: SCORE_W];

  // Strict greater-than keeps the earliest (lowest) index on ties.
  always_comb begin
    idx     = best_idx;
    max_val = best_max;
    if (load) begin
      idx     = index;
      max_val = cur;
    end else if (step && ($signed(cur) > $signed(best_max))) begin
      idx     = index;
      max_val = cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx <= '0;
      best_max <= '0;
    end else begin
      best_idx <= idx;
      best_max <= max_val;
    end
  end

endmodule

// File: rtl/mlp_infer_seq.sv
// Self-sequencing MNIST MLP inference controller: streams pixels into layer1,
// sweeps layer2, runs a registered argmax and reports the predicted digit.
module mlp_infer_seq
  import mlp_infer_seq_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_HIDDEN  = DEF_NUM_HIDDEN,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int PIX_W       = DEF_PIX_W,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int L1_LAT      = DEF_L1_LAT,
  parameter int L2_LAT      = DEF_L2_LAT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [PIX_W-1:0]                 pix_data,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  output logic [PIX_W-1:0]                 l1_pixel,
  output logic [width_of(NUM_INPUTS)-1:0]  l1_addr,
  output logic                             l1_valid,
  output logic                             layer_clr,
  output logic [width_of(NUM_HIDDEN)-1:0]  l2_addr,
  output logic                             l2_en,
  input  logic [NUM_CLASSES*SCORE_W-1:0]   l2_scores,
  output logic                             busy,
  output logic                             done,
  output logic [width_of(NUM_CLASSES)-1:0] digit,
  output logic [SCORE_W-1:0]               max_score,
  output logic [2:0]                       dbg_state
);

  localparam int AW1 = width_of(NUM_INPUTS);
  localparam int AW2 = width_of(NUM_HIDDEN);
  localparam int CW  = width_of(NUM_CLASSES);
  localparam int DW  = width_of(((L1_LAT > L2_LAT) ? L1_LAT : L2_LAT) + 1);

  state_t          state;
  logic [AW1-1:0]  pix_cnt;
  logic [CW-1:0]   cls;
  logic [DW-1:0]   drain_cnt;
  logic [CW-1:0]   am_idx;
  logic [SCORE_W-1:0] am_max;
  logic            am_load;
  logic            am_step;

  assign am_load   = (state == S_ARGMAX) && (cls == '0);
  assign am_step   = (state == S_ARGMAX) && (cls != '0);
  assign dbg_state = state;

  seq_argmax #(
    .SCORE_W     (SCORE_W),
    .NUM_CLASSES (NUM_CLASSES)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .load    (am_load),
    .step    (am_step),
    .index   (cls),
    .scores  (l2_scores),
    .idx     (am_idx),
    .max_val (am_max)
  );

  // Pixel stream: a beat transfers on a rising edge where pix_valid && pix_ready;
  // pix_ready is high exactly while in L1_RUN, and pix_data is not looked at otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pix_ready <= 1'b0;
      l1_pixel  <= '0;
      l1_addr   <= '0;
      l1_valid  <= 1'b0;
      layer_clr <= 1'b0;
      l2_addr   <= '0;
      l2_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      digit     <= '0;
      max_score <= '0;
      pix_cnt   <= '0;
      cls       <= '0;
      drain_cnt <= '0;
    end else begin
      layer_clr <= 1'b0;
      l1_valid  <= 1'b0;
      done      <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        pix_ready <= 1'b0;
        l2_en     <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            state     <= S_CLR;
            layer_clr <= 1'b1;
            busy      <= 1'b1;
            pix_cnt   <= '0;
            l1_addr   <= '0;
            l2_addr   <= '0;
          end
          S_CLR: begin
            state     <= S_L1_RUN;
            pix_ready <= 1'b1;
          end
          S_L1_RUN: if (pix_valid) begin
            l1_pixel <= pix_data;
            l1_addr  <= pix_cnt;
            l1_valid <= 1'b1;
            pix_cnt  <= pix_cnt + 1'b1;
            if (pix_cnt == AW1'(NUM_INPUTS - 1)) begin
              pix_ready <= 1'b0;
              if (L1_LAT > 0) begin
                state     <= S_L1_DRAIN;
                drain_cnt <= DW'(L1_LAT - 1);
              end else begin
                state   <= S_L2_RUN;
                l2_en   <= 1'b1;
                l2_addr <= '0;
              end
            end
          end
          S_L1_DRAIN: begin
            if (drain_cnt == '0) begin
              state   <= S_L2_RUN;
              l2_en   <= 1'b1;
              l2_addr <= '0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          S_L2_RUN: begin
            if (l2_addr == AW2'(NUM_HIDDEN - 1)) begin
              cls <= '0;
              if (L2_LAT > 0) begin
                state     <= S_L2_DRAIN;
                drain_cnt <= DW'(L2_LAT - 1);
              end else begin
                state <= S_ARGMAX;
              end
            end else begin
              l2_addr <= l2_addr + 1'b1;
            end
          end
          S_L2_DRAIN: begin
            if (drain_cnt == '0) begin
              state <= S_ARGMAX;
              cls   <= '0;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          S_ARGMAX: begin
            if (cls == CW'(NUM_CLASSES - 1)) begin
              state     <= S_DONE;
              done      <= 1'b1;
              digit     <= am_idx;
              max_score <= am_max;
            end else begin
              cls <= cls + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            l2_en <= 1'b0;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlp_infer_seq.sv
// Directed bench for mlp_infer_seq at default sizes: full inferences with
// hand-picked scores, stalls, abort, asynchronous reset and ignored start.
module tb_mlp_infer_seq;

  localparam int NI = 784;
  localparam int NH = 128;
  localparam int NC = 10;
  localparam int SW = 48;
  localparam int EW = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [7:0]      pix_data = '0;
  logic            pix_valid = 1'b0;
  logic            pix_ready;
  logic [7:0]      l1_pixel;
  logic [9:0]      l1_addr;
  logic            l1_valid;
  logic            layer_clr;
  logic [6:0]      l2_addr;
  logic            l2_en;
  logic [NC*SW-1:0] l2_scores = '0;
  logic            busy;
  logic            done;
  logic [3:0]      digit;
  logic [SW-1:0]   max_score;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // monitor-owned counters
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int clr_cnt = 0;
  int l2_en_cyc = 0;
  int l1v_cnt = 0;
  int l2_hits [NH];
  logic [3:0]    done_digit = '0;
  logic [SW-1:0] done_max = '0;
  logic          prev_l2_en = 1'b0;
  logic [6:0]    prev_l2_addr = '0;

  int start_cyc = 0;
  longint sc [NC];
  logic [EW-1:0] exp_q[$];

  mlp_infer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .l1_pixel  (l1_pixel),
    .l1_addr   (l1_addr),
    .l1_valid  (l1_valid),
    .layer_clr (layer_clr),
    .l2_addr   (l2_addr),
    .l2_en     (l2_en),
    .l2_scores (l2_scores),
    .busy      (busy),
    .done      (done),
    .digit     (digit),
    .max_score (max_score),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) begin
      done_cnt   = done_cnt + 1;
      done_cyc   = cyc;
      done_digit = digit;
      done_max   = max_score;
    end
    if (layer_clr) clr_cnt = clr_cnt + 1;
    if (l1_valid) l1v_cnt = l1v_cnt + 1;
    if (l2_en) l2_en_cyc = l2_en_cyc + 1;
    if (l2_en && (!prev_l2_en || (l2_addr != prev_l2_addr)))
      l2_hits[l2_addr] = l2_hits[l2_addr] + 1;
    prev_l2_en   = l2_en;
    prev_l2_addr = l2_addr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int n);
    logic [31:0] v;
    v = n * 37 + 11;
    return v[7:0];
  endfunction

  task automatic pack_scores();
    for (int i = 0; i < NC; i++) l2_scores[i*SW +: SW] = sc[i][SW-1:0];
  endtask

  task automatic load_exp();
    exp_q.delete();
    for (int n = 0; n < NI; n++) exp_q.push_back({10'(n), pix_of(n)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // driver: feeds n_beats pixels; in stall mode two idle cycles follow every even beat
  task automatic drive_pixels(input int stall, input int n_beats);
    for (int n = 0; n < n_beats; n++) begin
      logic acc;
      int   w;
      pix_valid = 1'b1;
      pix_data  = pix_of(n);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 50) begin
        @(negedge clk);
        acc = pix_ready;
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        check("pix_accept", {63'b0, acc}, 64'd1);
        break;
      end
      check("l1_beat", {45'b0, l1_valid, l1_addr, l1_pixel}, {45'b0, 1'b1, exp_q.pop_front()});
      if (stall != 0 && (n % 2) == 0) begin
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_cnt == base && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 0);
    check({tag, "_l1_valid"}, l1_valid, 0);
    check({tag, "_l1_addr"}, l1_addr, 0);
    check({tag, "_l1_pixel"}, l1_pixel, 0);
    check({tag, "_layer_clr"}, layer_clr, 0);
    check({tag, "_l2_addr"}, l2_addr, 0);
    check({tag, "_l2_en"}, l2_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_digit"}, digit, 0);
    check({tag, "_max_score"}, max_score, 0);
  endtask

  task automatic do_run(input string tag, input int stall, input int extra_start,
                        input int exp_lat, input int exp_digit, input longint exp_max);
    int d0, c0, e0, v0, bad;
    int hs [NH];
    logic [SW-1:0] em;
    em = exp_max[SW-1:0];
    d0 = done_cnt; c0 = clr_cnt; e0 = l2_en_cyc; v0 = l1v_cnt;
    hs = l2_hits;
    pack_scores();
    load_exp();
    pulse_start();
    drive_pixels(stall, NI);
    check({tag, "_ready_drop"}, pix_ready, 0);
    if (extra_start != 0) begin
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_ignores_start"}, busy, 1);
    end
    wait_done(d0);
    repeat (5) @(negedge clk);
    #1;
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_latency"}, done_cyc - start_cyc, exp_lat);
    check({tag, "_digit_at_done"}, done_digit, exp_digit);
    check({tag, "_max_at_done"}, done_max, em);
    check({tag, "_digit_hold"}, digit, exp_digit);
    check({tag, "_max_hold"}, max_score, em);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_l2_en"}, l2_en, 0);
    check({tag, "_clr_pulses"}, clr_cnt - c0, 1);
    check({tag, "_l1_pulses"}, l1v_cnt - v0, NI);
    check({tag, "_l1_left"}, exp_q.size(), 0);
    check({tag, "_l2_en_cycles"}, l2_en_cyc - e0, NH + 2 + NC + 1);
    bad = 0;
    for (int a = 0; a < NH; a++) if (l2_hits[a] - hs[a] != 1) bad++;
    check({tag, "_l2_cover"}, bad, 0);
  endtask

  initial begin
    int d0, w;
    for (int a = 0; a < NH; a++) l2_hits[a] = 0;

    // power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    rst = 1'b0;

    sc = '{5, -3, 900, 12, 0, -100, 899, 901, 7, 0};
    do_run("basic", 0, 0, 928, 7, 901);

    sc = '{-64'sd140737488355328, -1000, -7, -2, -50, -3, -9, -100, -20, -1};
    do_run("neg", 0, 0, 928, 9, -1);

    sc = '{1, 2, 3, 100, -4, 99, 100, 0, 50, -100};
    do_run("tie", 0, 0, 928, 3, 100);

    sc = '{-1, 3, -64'sd140737488355328, 2, 0, 1, -5, 3, 2, 1};
    do_run("stall", 1, 0, 928 + 784, 1, 3);

    // abort in L2_RUN at address 50
    sc = '{0, 0, 0, 0, 0, 1000, 0, 0, 0, 0};
    pack_scores();
    load_exp();
    d0 = done_cnt;
    pulse_start();
    drive_pixels(0, NI);
    w = 0;
    while (!(l2_en && l2_addr == 7'd50) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("abort_reach", l2_addr, 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_l2_en", l2_en, 0);
    check("abort_pix_ready", pix_ready, 0);
    check("abort_done", done, 0);
    repeat (20) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_digit", digit, 1);
    check("abort_max", max_score, 3);
    check("abort_l1_left", exp_q.size(), 0);

    sc = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 95};
    do_run("after_abort", 0, 0, 928, 9, 95);

    // asynchronous reset between edges in L1_RUN
    pack_scores();
    load_exp();
    pulse_start();
    drive_pixels(0, 100);
    check("midrst_pre_addr", l1_addr, 99);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("postrst");

    sc = '{500, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    do_run("start_busy", 0, 1, 928, 0, 500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
